multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Sequencing controller for the multicycle RV32I datapath. It replaces the single-cycle combinational decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It also adds memory wait-state handshaking, the full branch set (signed and unsigned), jal/jalr, lui/auipc, and an illegal-instruction trap. It sits beside the datapath, driving the PC, IR, address, ALU-operand and writeback muxes every cycle.

## Interface
- `UNSIGNED_BR`, default 1. When 1, bltu/bgeu are decoded. When 0, funct3 110/111 on a branch traps as illegal.
- `MEM_WAIT`, default 1. When 1, memory states hold until `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `op`, in, 7: instruction bits [6:0], from IR.
- `funct3`, in, 3: IR[14:12].
- `funct7b5`, in, 1: IR[30].
- `Zero`, `Negative`, `Carry`, `Overflow`, in, 1 each: ALU flags of the current cycle's operation. `Carry` = 1 means no borrow on subtract.
- `mem_ready`, in, 1: memory completed the access this cycle.
- `PCWrite`, out, 1: load PC from Result.
- `IRWrite`, out, 1: latch instruction and OldPC.
- `AdrSrc`, out, 1: 0 = PC, 1 = ALUOut.
- `MemWrite`, out, 1: store strobe.
- `MemRead`, out, 1: read request.
- `RegWrite`, out, 1: register-file write.
- `ResultSrc`, out, 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`, out, 2: 00 = PC, 01 = OldPC, 10 = rs1 (A), 11 = zero.
- `ALUSrcB`, out, 2: 00 = rs2 (B), 01 = Imm, 10 = constant 4.
- `ImmSrc`, out, 3: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `ALUControl`, out, 4: ALU operation code (encoding under Operation).
- `illegal_instr`, out, 1: high in TRAP.
- `state`, out, 4: current state encoding, for debug.

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
- EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, JALR = 11, UPPER = 12, TRAP = 13
- Unused encodings return to FETCH.

ALUControl encoding:
- 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
- 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra

ALU decode for EXECR and EXECI, by funct3:
- 000: sub if op[5] & funct7b5, else add
- 001: sll; 010: slt; 011: sltu; 100: xor
- 101: sra if funct7b5, else srl
- 110: or; 111: and

`ImmSrc` is combinational from `op` in every state. Unknown op gives 000.

Per-state outputs and transitions. Any output not listed is 0.
- **FETCH:** MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite are driven equal to `mem_ready`. On `mem_ready` → DECODE, otherwise stay.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 / 0010111 → UPPER
  - else → TRAP
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, add. → MEMREAD if op[5]=0, else MEMWRITE.
- **MEMREAD:** MemRead=1, AdrSrc=1. On `mem_ready` → MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1. → FETCH.
- **MEMWRITE:** MemWrite=1, AdrSrc=1, held until `mem_ready`. → FETCH on `mem_ready`.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, decoded op. → ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, decoded op. funct7b5 selects sub only when op[5]=1. → ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. → FETCH.
- **BRANCH:** ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=take. → FETCH. `take` by funct3:
  - 000 beq: Zero
  - 001 bne: ~Zero
  - 100 blt: Negative^Overflow
  - 101 bge: ~(Negative^Overflow)
  - 110 bltu: ~Carry
  - 111 bgeu: Carry
  - 010/011, or 11x with UNSIGNED_BR=0: → TRAP, no PC write.
- **JALR:** ALUSrcA=10, ALUSrcB=01, add (target into ALUOut). → JAL.
- **JAL:** ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. → ALUWB (writes OldPC+4).
- **UPPER:** ALUSrcA = 11 if op[5], else 01. ALUSrcB=01, add. → ALUWB.
- **TRAP:** illegal_instr=1, all enables 0. Holds until reset.

## Timing
- Moore outputs, except FETCH IRWrite/PCWrite and the BRANCH PCWrite, which also depend on inputs in the same cycle.
- On a clock edge with `rst_n`=0, state becomes FETCH.
- While `rst_n`=0, PCWrite, IRWrite, MemWrite, MemRead and RegWrite are forced to 0, and illegal_instr is 0. Reset mid-instruction discards it with no writes.
- Cycles with zero wait states:
  - branch 3
  - R/I-type, sw, jal, lui, auipc 4
  - lw, jalr 5
- Each wait cycle (`mem_ready`=0) adds one cycle to FETCH, MEMREAD or MEMWRITE. Outputs stay stable throughout the wait.
- MEM_WAIT=0: every memory state is exactly 1 cycle.

## Test plan
- Reset then add (op 0110011, f3 000, f7b5 0), `mem_ready`=1: state sequence 0,1,6,8,0. ALUControl=0000 in EXECR. RegWrite=1 only in ALUWB.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 in MEMREAD: total 10 cycles. IRWrite pulses once. RegWrite pulses once in MEMWB with ResultSrc=01.
- Branch sweep, all six funct3 with flag sets:
  - Z=1 on beq: PCWrite=1 in BRANCH.
  - Carry=1 on bltu: no write.
  - N=1, V=1 on blt: no write.
  - UNSIGNED_BR=0 with f3=110: TRAP, illegal_instr=1.
- jalr: states 0,1,11,10,8,0. PCWrite in JAL with ResultSrc=00. RegWrite in ALUWB.
- lui then auipc: ALUSrcA=11 and then 01 in UPPER. ImmSrc=011 throughout.
- sw held 2 wait cycles, `rst_n` dropped in the 2nd: MemWrite low from that cycle, state=0 after the edge, no RegWrite or PCWrite.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle RV32I datapath: fetch/decode/execute/memory/writeback,
// memory wait states, full branch set, jal/jalr, lui/auipc and an illegal-instruction trap.
module multicycle_control_unit #(
    parameter bit UNSIGNED_BR = 1'b1,
    parameter bit MEM_WAIT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Carry,
    input  logic       Overflow,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR    = 4'd11,
        S_UPPER  = 4'd12, S_TRAP   = 4'd13
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8, ALU_SRA = 4'd9;

    state_t cur, nxt;
    logic   ready;
    logic   take;
    logic   br_legal;
    logic [3:0] alu_dec;

    assign ready = MEM_WAIT ? mem_ready : 1'b1;
    assign state = cur;

    // funct7b5 only means sub on register-register ops (op[5]=1); addi ignores it.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    end

    always_comb begin
        take     = 1'b0;
        br_legal = 1'b1;
        case (funct3)
            3'b000:  take = Zero;
            3'b001:  take = ~Zero;
            3'b100:  take = Negative ^ Overflow;
            3'b101:  take = ~(Negative ^ Overflow);
            3'b110:  begin take = ~Carry; br_legal = UNSIGNED_BR; end
            3'b111:  begin take = Carry;  br_legal = UNSIGNED_BR; end
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: ImmSrc = 3'b000;
            7'b0100011:                         ImmSrc = 3'b001;
            7'b1100011:                         ImmSrc = 3'b010;
            7'b0110111, 7'b0010111:             ImmSrc = 3'b011;
            7'b1101111:                         ImmSrc = 3'b100;
            default:                            ImmSrc = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt           = S_FETCH;
        PCWrite       = 1'b0;
        IRWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        illegal_instr = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
                nxt       = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: nxt = S_MEMADR;
                    7'b0110011:             nxt = S_EXECR;
                    7'b0010011:             nxt = S_EXECI;
                    7'b1100011:             nxt = S_BRANCH;
                    7'b1101111:             nxt = S_JAL;
                    7'b1100111:             nxt = S_JALR;
                    7'b0110111, 7'b0010111: nxt = S_UPPER;
                    default:                nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                nxt     = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
                nxt     = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                nxt      = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
                nxt        = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                nxt        = S_ALUWB;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = take & br_legal;
                nxt        = br_legal ? S_FETCH : S_TRAP;
            end
            // jalr parks its target in ALUOut, then shares the link/jump step with jal.
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                nxt     = S_JAL;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                nxt     = S_ALUWB;
            end
            S_UPPER: begin
                ALUSrcA = op[5] ? 2'b11 : 2'b01;
                ALUSrcB = 2'b01;
                nxt     = S_ALUWB;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                nxt           = S_TRAP;
            end
            default: nxt = S_FETCH;
        endcase
        // Reset cancels every side effect of the in-flight instruction.
        if (!rst_n) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            MemWrite      = 1'b0;
            MemRead       = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of instructions with expected state sequences,
// per-cycle expected output words through a queue, plus wait-state, reset and parameter sequences.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, Negative, Carry, Overflow;
    logic       mem_ready;
    logic       PCWrite, IRWrite, AdrSrc, MemWrite, MemRead, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl, state;
    logic       PCWrite2, IRWrite2, AdrSrc2, MemWrite2, MemRead2, RegWrite2, illegal2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2;
    logic [2:0] ImmSrc2;
    logic [3:0] ALUControl2, state2;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .MemRead(MemRead), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .illegal_instr(illegal_instr), .state(state)
    );

    multicycle_control_unit #(.UNSIGNED_BR(1'b0), .MEM_WAIT(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .mem_ready(mem_ready), .PCWrite(PCWrite2), .IRWrite(IRWrite2), .AdrSrc(AdrSrc2),
        .MemWrite(MemWrite2), .MemRead(MemRead2), .RegWrite(RegWrite2), .ResultSrc(ResultSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2), .ALUControl(ALUControl2),
        .illegal_instr(illegal2), .state(state2)
    );

    // seq holds one state per cycle, cycle 0 in the top nibble.
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  flg;   // Z N C V
        logic [2:0]  imm;
        logic [3:0]  alu;
        logic        take;
        logic [3:0]  n;
        logic [23:0] seq;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ir_cnt = 0;
    int          rw_cnt = 0;
    int          pc_cnt = 0;

    function automatic vec_t mk(logic [6:0] o, logic [2:0] f3, logic f7, logic [3:0] flg,
                                logic [2:0] imm, logic [3:0] alu, logic take,
                                logic [3:0] n, logic [23:0] seq);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.flg = flg; v.imm = imm;
        v.alu = alu; v.take = take; v.n = n; v.seq = seq;
        return v;
    endfunction

    function automatic logic [23:0] exp_word(vec_t v, logic [3:0] st, logic rdy, logic rst);
        logic pcw, irw, adr, mw, mr, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [3:0] alu;
        pcw = 1'b0; irw = 1'b0; adr = 1'b0; mw = 1'b0; mr = 1'b0; rw = 1'b0; ill = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 4'h0;
        case (st)
            4'd0:  begin mr = 1'b1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  begin mr = 1'b1; adr = 1'b1; end
            4'd4:  begin rs = 2'b01; rw = 1'b1; end
            4'd5:  begin mw = 1'b1; adr = 1'b1; end
            4'd6:  begin sa = 2'b10; alu = v.alu; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; alu = v.alu; end
            4'd8:  rw = 1'b1;
            4'd9:  begin sa = 2'b10; alu = 4'h1; pcw = v.take; end
            4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            4'd11: begin sa = 2'b10; sb = 2'b01; end
            4'd12: begin sa = v.op[5] ? 2'b11 : 2'b01; sb = 2'b01; end
            4'd13: ill = 1'b1;
            default: ;
        endcase
        if (!rst) begin
            pcw = 1'b0; irw = 1'b0; mw = 1'b0; mr = 1'b0; rw = 1'b0; ill = 1'b0;
        end
        return {st, pcw, irw, adr, mw, mr, rw, rs, sa, sb, v.imm, alu, ill};
    endfunction

    function automatic logic [23:0] act_word();
        return {state, PCWrite, IRWrite, AdrSrc, MemWrite, MemRead, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr};
    endfunction

    task automatic check(string name, logic [23:0] got, logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic apply(vec_t v);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7;
        {Zero, Negative, Carry, Overflow} = v.flg;
    endtask

    // One clock: push the expected word, compare it against the DUT mid-cycle.
    task automatic step(vec_t v, logic [3:0] st, logic rdy, logic rst, string name);
        rst_n = rst;
        mem_ready = rdy;
        exp_q.push_back(exp_word(v, st, rdy, rst));
        @(negedge clk);
        if (IRWrite)  ir_cnt++;
        if (RegWrite) rw_cnt++;
        if (PCWrite)  pc_cnt++;
        check(name, act_word(), exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic run_vec(vec_t v, int k);
        logic [3:0] st;
        apply(v);
        st = 4'd0;
        for (int i = 0; i < int'(v.n); i++) begin
            st = v.seq[23 - 4*i -: 4];
            step(v, st, 1'b1, 1'b1, $sformatf("vec%0d_c%0d", k, i));
        end
        if (st == 4'd13) step(v, 4'd13, 1'b1, 1'b0, $sformatf("vec%0d_trap_rst", k));
    endtask

    task automatic dut2_seq(string name, logic [3:0] n, logic [23:0] seq, logic [3:0] ill_at);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            check($sformatf("%s_st%0d", name, i), {20'd0, state2}, {20'd0, seq[23 - 4*i -: 4]});
            if (i == 0)
                check($sformatf("%s_fetch_pcw", name), {22'd0, PCWrite2, IRWrite2}, 24'd3);
            if (i == int'(ill_at))
                check($sformatf("%s_illegal", name), {23'd0, illegal2}, 24'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        // R-type
        tbl.push_back(mk(7'b0110011, 3'b000, 1'b0, 4'h0, 3'b000, 4'h0, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b000, 1'b1, 4'h0, 3'b000, 4'h1, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b001, 1'b0, 4'h0, 3'b000, 4'h7, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b010, 1'b0, 4'h0, 3'b000, 4'h5, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b011, 1'b0, 4'h0, 3'b000, 4'h6, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b100, 1'b0, 4'h0, 3'b000, 4'h4, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b101, 1'b0, 4'h0, 3'b000, 4'h8, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b101, 1'b1, 4'h0, 3'b000, 4'h9, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b110, 1'b0, 4'h0, 3'b000, 4'h3, 1'b0, 4, 24'h016800));
        tbl.push_back(mk(7'b0110011, 3'b111, 1'b0, 4'h0, 3'b000, 4'h2, 1'b0, 4, 24'h016800));
        // I-type: funct7b5 set on addi must still add
        tbl.push_back(mk(7'b0010011, 3'b000, 1'b1, 4'h0, 3'b000, 4'h0, 1'b0, 4, 24'h017800));
        tbl.push_back(mk(7'b0010011, 3'b101, 1'b1, 4'h0, 3'b000, 4'h9, 1'b0, 4, 24'h017800));
        tbl.push_back(mk(7'b0010011, 3'b111, 1'b0, 4'h0, 3'b000, 4'h2, 1'b0, 4, 24'h017800));
        // loads/stores
        tbl.push_back(mk(7'b0000011, 3'b010, 1'b0, 4'h0, 3'b000, 4'h0, 1'b0, 5, 24'h012340));
        tbl.push_back(mk(7'b0100011, 3'b010, 1'b0, 4'h0, 3'b001, 4'h0, 1'b0, 4, 24'h012500));
        // branches, flags = {Z,N,C,V}
        tbl.push_back(mk(7'b1100011, 3'b000, 1'b0, 4'b1000, 3'b010, 4'h0, 1'b1, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b000, 1'b0, 4'b0000, 3'b010, 4'h0, 1'b0, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b001, 1'b0, 4'b1000, 3'b010, 4'h0, 1'b0, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b001, 1'b0, 4'b0000, 3'b010, 4'h0, 1'b1, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b100, 1'b0, 4'b0100, 3'b010, 4'h0, 1'b1, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b100, 1'b0, 4'b0101, 3'b010, 4'h0, 1'b0, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b101, 1'b0, 4'b0000, 3'b010, 4'h0, 1'b1, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b101, 1'b0, 4'b0100, 3'b010, 4'h0, 1'b0, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b110, 1'b0, 4'b0000, 3'b010, 4'h0, 1'b1, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b110, 1'b0, 4'b0010, 3'b010, 4'h0, 1'b0, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b111, 1'b0, 4'b0010, 3'b010, 4'h0, 1'b1, 3, 24'h019000));
        tbl.push_back(mk(7'b1100011, 3'b111, 1'b0, 4'b0000, 3'b010, 4'h0, 1'b0, 3, 24'h019000));
        // jumps and upper-immediates
        tbl.push_back(mk(7'b1101111, 3'b000, 1'b0, 4'h0, 3'b100, 4'h0, 1'b0, 4, 24'h01A800));
        tbl.push_back(mk(7'b1100111, 3'b000, 1'b0, 4'h0, 3'b000, 4'h0, 1'b0, 5, 24'h01BA80));
        tbl.push_back(mk(7'b0110111, 3'b000, 1'b0, 4'h0, 3'b011, 4'h0, 1'b0, 4, 24'h01C800));
        tbl.push_back(mk(7'b0010111, 3'b000, 1'b0, 4'h0, 3'b011, 4'h0, 1'b0, 4, 24'h01C800));
        // traps: unknown opcode, and branch funct3 010
        tbl.push_back(mk(7'b0000000, 3'b000, 1'b0, 4'h0, 3'b000, 4'h0, 1'b0, 4, 24'h01DD00));
        tbl.push_back(mk(7'b1100011, 3'b010, 1'b0, 4'h0, 3'b010, 4'h0, 1'b0, 5, 24'h019DD0));

        // reset state
        rst_n = 1'b0;
        mem_ready = 1'b1;
        apply(tbl[0]);
        repeat (2) @(posedge clk);
        #1;
        step(tbl[0], 4'd0, 1'b1, 1'b0, "reset");

        foreach (tbl[k]) run_vec(tbl[k], k);

        // lw: 2 wait cycles in FETCH, 3 in MEMREAD -> 10 cycles
        v = tbl[13];
        apply(v);
        ir_cnt = 0; rw_cnt = 0;
        step(v, 4'd0, 1'b0, 1'b1, "lw_w0");
        step(v, 4'd0, 1'b0, 1'b1, "lw_w1");
        step(v, 4'd0, 1'b1, 1'b1, "lw_w2");
        step(v, 4'd1, 1'b1, 1'b1, "lw_w3");
        step(v, 4'd2, 1'b1, 1'b1, "lw_w4");
        for (int i = 0; i < 3; i++) step(v, 4'd3, 1'b0, 1'b1, $sformatf("lw_rd%0d", i));
        step(v, 4'd3, 1'b1, 1'b1, "lw_w8");
        step(v, 4'd4, 1'b1, 1'b1, "lw_w9");
        check("lw_irwrite_pulses", 24'(ir_cnt), 24'd1);
        check("lw_regwrite_pulses", 24'(rw_cnt), 24'd1);

        // sw held in MEMWRITE, reset asserted during the second wait cycle
        v = tbl[14];
        apply(v);
        rw_cnt = 0; pc_cnt = 0;
        step(v, 4'd0, 1'b1, 1'b1, "sw_c0");
        step(v, 4'd1, 1'b1, 1'b1, "sw_c1");
        step(v, 4'd2, 1'b1, 1'b1, "sw_c2");
        pc_cnt = 0;
        step(v, 4'd5, 1'b0, 1'b1, "sw_wait");
        step(v, 4'd5, 1'b0, 1'b0, "sw_rst");
        check("sw_no_regwrite", 24'(rw_cnt), 24'd0);
        check("sw_no_pcwrite", 24'(pc_cnt), 24'd0);
        step(v, 4'd0, 1'b1, 1'b1, "sw_after_rst");
        step(v, 4'd1, 1'b1, 1'b1, "sw_r1");
        step(v, 4'd2, 1'b1, 1'b1, "sw_r2");
        step(v, 4'd5, 1'b1, 1'b1, "sw_r3");

        // UNSIGNED_BR=0, MEM_WAIT=0 instance, mem_ready held low
        apply(tbl[23]);
        dut2_seq("d2_bltu", 4, 24'h019D00, 4'd3);
        apply(tbl[13]);
        dut2_seq("d2_lw", 6, 24'h012340, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
